// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse controller slice: default geometry,
// timeout budget, FSM state encoding and the segment-index type.
package efuse_pkg;

    // Default geometry: four 64-bit segments make up the 256-bit shadow.
    localparam int NR_DEF   = 64;
    localparam int RSEL_DEF = 4;
    // Default number of wait cycles before a read is declared lost.
    localparam int TMO_DEF  = 1023;

    // FSM state encoding (plain constants so older tools and checkers can bind to it).
    typedef logic [2:0] state_t;
    localparam state_t ST_BOOT_ISSUE = 3'd0;
    localparam state_t ST_BOOT_WAIT  = 3'd1;
    localparam state_t ST_IDLE       = 3'd2;
    localparam state_t ST_SW_ISSUE   = 3'd3;
    localparam state_t ST_SW_WAIT    = 3'd4;
    localparam state_t ST_PGM        = 3'd5;

    // Segment index for the default geometry.
    typedef logic [$clog2(RSEL_DEF)-1:0] seg_t;

    // True for the two states in which a read is outstanding.
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_BOOT_WAIT) || (st == ST_SW_WAIT);
    endfunction

endpackage

// File: rtl/efuse_tmo_cnt.sv
// Saturating read-timeout counter. Cleared when a read is issued, counts
// while a read is outstanding, and flags expiry once it has reached TMO.
module efuse_tmo_cnt #(
    parameter int TMO = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TMO);

    logic [CW-1:0] cnt;

    // Count wait cycles; clear has priority and the count sticks at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry is only meaningful while a read is outstanding.
    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/efuse_ctrl_seq.sv
// eFuse read sequencer and array arbiter. Owns the full shadow copy of the
// fuse array: loads every segment after reset / reload / programming, then
// serves single-segment software reads and hands the array to the program
// engine on request.
//
// Handshakes:
//   efuse_read : rd_start_o is a one-cycle pulse issued only while rd_busy_i
//                is low; rd_sel_o is held until the matching rd_done_i pulse
//                (which qualifies rd_data_i) or until the read times out. At
//                most one read is ever outstanding.
//   software   : sw_rd_req_i is a level held (with stable sw_rd_sel_i) until
//                the one-cycle sw_rd_ack_o; data/err are valid in the ack
//                cycle and the requester drops req in the following cycle.
//   program    : pgm_req_i level; pgm_gnt_o follows one cycle after entry
//                and falls one cycle after the request drops.
module efuse_ctrl_seq
    import efuse_pkg::*;
#(
    parameter int NR   = NR_DEF,
    parameter int RSEL = RSEL_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    rd_start_o,
    output logic [$clog2(RSEL)-1:0] rd_sel_o,
    input  logic                    rd_done_i,
    input  logic [NR-1:0]           rd_data_i,
    input  logic                    rd_busy_i,
    input  logic                    sw_rd_req_i,
    input  logic [$clog2(RSEL)-1:0] sw_rd_sel_i,
    output logic                    sw_rd_ack_o,
    output logic [NR-1:0]           sw_rd_data_o,
    output logic                    sw_rd_err_o,
    input  logic                    pgm_req_i,
    output logic                    pgm_gnt_o,
    input  logic                    reload_i,
    output logic [NR*RSEL-1:0]      shadow_o,
    output logic                    shadow_vld_o,
    output logic                    load_done_o,
    output logic                    timeout_err_o
);

    localparam int SW = $clog2(RSEL);
    localparam logic [SW-1:0] LAST_SEG = SW'(RSEL - 1);

    state_t        state;
    logic [SW-1:0] seg;          // segment being loaded in the current pass
    logic [SW-1:0] sw_sel_q;     // software segment captured when leaving IDLE
    logic          pass_err;     // a timeout happened somewhere in this pass
    logic          reload_pend;  // reload seen while busy; serviced in IDLE
    logic [NR-1:0] shadow_q [RSEL];

    logic          issue;
    logic          tmo_en;
    logic          tmo_exp;

    // A read is launched from either issue state as soon as efuse_read is free.
    assign issue  = ((state == ST_BOOT_ISSUE) || (state == ST_SW_ISSUE)) && !rd_busy_i;
    assign tmo_en = is_wait_state(state);

    efuse_tmo_cnt #(
        .TMO (TMO)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (issue),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    // Flatten the shadow array onto the output bus, segment k at [k*NR +: NR].
    for (genvar k = 0; k < RSEL; k++) begin : g_shadow
        assign shadow_o[k*NR +: NR] = shadow_q[k];
    end

    // Main sequencer: load passes, software reads, program grant, reload tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT_ISSUE;
            seg           <= '0;
            sw_sel_q      <= '0;
            pass_err      <= 1'b0;
            reload_pend   <= 1'b0;
            rd_start_o    <= 1'b0;
            rd_sel_o      <= '0;
            sw_rd_ack_o   <= 1'b0;
            sw_rd_data_o  <= '0;
            sw_rd_err_o   <= 1'b0;
            pgm_gnt_o     <= 1'b0;
            shadow_vld_o  <= 1'b0;
            load_done_o   <= 1'b0;
            timeout_err_o <= 1'b0;
            for (int k = 0; k < RSEL; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            // Pulses default low every cycle.
            rd_start_o  <= 1'b0;
            sw_rd_ack_o <= 1'b0;
            sw_rd_err_o <= 1'b0;
            load_done_o <= 1'b0;

            // Outside IDLE a reload cannot act yet; remember it (repeats merge).
            if (reload_i && (state != ST_IDLE)) begin
                reload_pend <= 1'b1;
            end

            case (state)
                ST_BOOT_ISSUE: begin
                    if (!rd_busy_i) begin
                        rd_start_o <= 1'b1;
                        rd_sel_o   <= seg;
                        state      <= ST_BOOT_WAIT;
                    end
                end

                ST_BOOT_WAIT: begin
                    // A done in the expiry cycle still counts as a good read.
                    if (rd_done_i || tmo_exp) begin
                        if (rd_done_i) begin
                            shadow_q[seg] <= rd_data_i;
                        end else begin
                            timeout_err_o <= 1'b1;
                            pass_err      <= 1'b1;
                        end
                        if (seg == LAST_SEG) begin
                            load_done_o  <= 1'b1;
                            shadow_vld_o <= !(pass_err || !rd_done_i);
                            state        <= ST_IDLE;
                        end else begin
                            seg   <= seg + SW'(1);
                            state <= ST_BOOT_ISSUE;
                        end
                    end
                end

                ST_IDLE: begin
                    if (reload_pend || reload_i) begin
                        reload_pend   <= 1'b0;
                        seg           <= '0;
                        pass_err      <= 1'b0;
                        shadow_vld_o  <= 1'b0;
                        timeout_err_o <= 1'b0;
                        state         <= ST_BOOT_ISSUE;
                    end else if (pgm_req_i) begin
                        state <= ST_PGM;
                    end else if (sw_rd_req_i && !sw_rd_ack_o) begin
                        // Ignore the request still held high during our own ack cycle.
                        sw_sel_q <= sw_rd_sel_i;
                        state    <= ST_SW_ISSUE;
                    end
                end

                ST_SW_ISSUE: begin
                    if (!rd_busy_i) begin
                        rd_start_o <= 1'b1;
                        rd_sel_o   <= sw_sel_q;
                        state      <= ST_SW_WAIT;
                    end
                end

                ST_SW_WAIT: begin
                    if (rd_done_i) begin
                        sw_rd_ack_o        <= 1'b1;
                        sw_rd_data_o       <= rd_data_i;
                        shadow_q[sw_sel_q] <= rd_data_i;
                        state              <= ST_IDLE;
                    end else if (tmo_exp) begin
                        sw_rd_ack_o   <= 1'b1;
                        sw_rd_data_o  <= '0;
                        sw_rd_err_o   <= 1'b1;
                        timeout_err_o <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                ST_PGM: begin
                    if (pgm_req_i) begin
                        pgm_gnt_o <= 1'b1;
                    end else begin
                        // Fuses may have changed: drop the grant and reload everything.
                        // Any reload requested meanwhile is covered by this pass.
                        pgm_gnt_o     <= 1'b0;
                        reload_pend   <= 1'b0;
                        seg           <= '0;
                        pass_err      <= 1'b0;
                        shadow_vld_o  <= 1'b0;
                        timeout_err_o <= 1'b0;
                        state         <= ST_BOOT_ISSUE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_ctrl_seq.sv
// Bench for efuse_ctrl_seq: a behavioural efuse_read responder, an output
// monitor popping expected starts / acks / load-pass results from queues,
// and a directed sequence of boot, software, program, timeout, reload and
// reset scenarios.
module tb_efuse_ctrl_seq;

    localparam int NR   = 64;
    localparam int RSEL = 4;
    localparam int TMO  = 16;
    localparam int SW   = $clog2(RSEL);
    localparam int EW   = NR*RSEL + 2;

    localparam int W_DONE  = 0;
    localparam int W_ACK   = 1;
    localparam int W_START = 2;
    localparam int W_GNT   = 3;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_start_o;
    logic [SW-1:0]     rd_sel_o;
    logic              rd_done_i;
    logic [NR-1:0]     rd_data_i;
    logic              rd_busy_i;
    logic              sw_rd_req_i;
    logic [SW-1:0]     sw_rd_sel_i;
    logic              sw_rd_ack_o;
    logic [NR-1:0]     sw_rd_data_o;
    logic              sw_rd_err_o;
    logic              pgm_req_i;
    logic              pgm_gnt_o;
    logic              reload_i;
    logic [NR*RSEL-1:0] shadow_o;
    logic              shadow_vld_o;
    logic              load_done_o;
    logic              timeout_err_o;

    always #5 clk = ~clk;

    efuse_ctrl_seq #(
        .NR   (NR),
        .RSEL (RSEL),
        .TMO  (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_start_o    (rd_start_o),
        .rd_sel_o      (rd_sel_o),
        .rd_done_i     (rd_done_i),
        .rd_data_i     (rd_data_i),
        .rd_busy_i     (rd_busy_i),
        .sw_rd_req_i   (sw_rd_req_i),
        .sw_rd_sel_i   (sw_rd_sel_i),
        .sw_rd_ack_o   (sw_rd_ack_o),
        .sw_rd_data_o  (sw_rd_data_o),
        .sw_rd_err_o   (sw_rd_err_o),
        .pgm_req_i     (pgm_req_i),
        .pgm_gnt_o     (pgm_gnt_o),
        .reload_i      (reload_i),
        .shadow_o      (shadow_o),
        .shadow_vld_o  (shadow_vld_o),
        .load_done_o   (load_done_o),
        .timeout_err_o (timeout_err_o)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [EW-1:0] start_q [$];   // expected rd_sel_o per start, in order
    logic [EW-1:0] ack_q   [$];   // expected {err, data} per software ack
    logic [EW-1:0] pass_q  [$];   // expected {vld, terr, shadow} per load_done

    logic [NR-1:0] mem    [RSEL]; // array contents the responder returns
    logic [NR-1:0] exp_sh [RSEL]; // expected shadow contents
    logic          noans_en   = 1'b0;
    int            noans_sel  = 0;
    logic          exact_mode = 1'b0;

    int   cyc = 0;
    int   start_cnt = 0;
    int   ack_cnt = 0;
    int   load_done_cnt = 0;
    int   done_at_ack = 0;
    int   noans_start_cyc = 0;
    int   terr_rise_cyc = 0;
    logic terr_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [NR*RSEL-1:0] pack_sh();
        logic [NR*RSEL-1:0] r;
        for (int k = 0; k < RSEL; k++) r[k*NR +: NR] = exp_sh[k];
        return r;
    endfunction

    // Queue one full load pass using the current mem / no-answer settings.
    task automatic push_pass();
        for (int k = 0; k < RSEL; k++) begin
            start_q.push_back(EW'(k));
            if (!(noans_en && (k == noans_sel))) exp_sh[k] = mem[k];
        end
        pass_q.push_back({!noans_en, noans_en, pack_sh()});
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            W_DONE:  return load_done_cnt;
            W_ACK:   return ack_cnt;
            W_START: return start_cnt;
            default: return int'(pgm_gnt_o);
        endcase
    endfunction

    // Bounded wait until a monitor counter reaches target.
    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cnt_of(which) >= target) break;
            @(negedge clk); #1;
        end
        check_eq(tag, EW'(cnt_of(which) >= target), EW'(1));
    endtask

    task automatic pulse_reload();
        reload_i = 1'b1;
        @(negedge clk); #1;
        reload_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_start"}, EW'(rd_start_o), '0);
        check_eq({tag, "_sel"}, EW'(rd_sel_o), '0);
        check_eq({tag, "_ack"}, EW'(sw_rd_ack_o), '0);
        check_eq({tag, "_swdata"}, EW'(sw_rd_data_o), '0);
        check_eq({tag, "_swerr"}, EW'(sw_rd_err_o), '0);
        check_eq({tag, "_gnt"}, EW'(pgm_gnt_o), '0);
        check_eq({tag, "_shadow"}, EW'(shadow_o), '0);
        check_eq({tag, "_vld"}, EW'(shadow_vld_o), '0);
        check_eq({tag, "_ldone"}, EW'(load_done_o), '0);
        check_eq({tag, "_terr"}, EW'(timeout_err_o), '0);
    endtask

    // ---------------- efuse_read responder ----------------
    initial begin : responder
        logic          outstanding;
        logic          answer;
        int            delay;
        logic [SW-1:0] cur_sel;
        outstanding = 1'b0;
        answer      = 1'b0;
        delay       = 0;
        cur_sel     = '0;
        rd_done_i   = 1'b0;
        rd_busy_i   = 1'b0;
        rd_data_i   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_done_i   = 1'b0;
                rd_busy_i   = 1'b0;
                rd_data_i   = '0;
                outstanding = 1'b0;
            end else begin
                if (rd_start_o) begin
                    check_eq("start_while_busy", EW'({outstanding, rd_busy_i}), '0);
                end
                if (rd_done_i) begin
                    rd_done_i   = 1'b0;
                    rd_busy_i   = 1'b0;
                    rd_data_i   = '0;
                    outstanding = 1'b0;
                end
                if (rd_start_o) begin
                    outstanding = 1'b1;
                    rd_busy_i   = 1'b1;
                    cur_sel     = rd_sel_o;
                    answer      = !(noans_en && (int'(rd_sel_o) == noans_sel));
                    delay       = !answer ? TMO + 4 : (exact_mode ? TMO : $urandom_range(3, 12));
                end else if (outstanding) begin
                    delay--;
                    if (delay == 0) begin
                        if (answer) begin
                            rd_done_i = 1'b1;
                            rd_data_i = mem[cur_sel];
                        end else begin
                            rd_busy_i   = 1'b0;
                            outstanding = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (rd_start_o) begin
                    start_cnt++;
                    check_eq("start_in_pgm", EW'(pgm_gnt_o), '0);
                    if (start_q.size() == 0) begin
                        check_eq("start_unexpected", EW'(rd_start_o), '0);
                    end else begin
                        e = start_q.pop_front();
                        check_eq("start_sel", EW'(rd_sel_o), e);
                    end
                    if (noans_en && (int'(rd_sel_o) == noans_sel)) noans_start_cyc = cyc;
                end
                if (timeout_err_o && !terr_prev) terr_rise_cyc = cyc;
                terr_prev = timeout_err_o;
                if (sw_rd_ack_o) begin
                    ack_cnt++;
                    done_at_ack = load_done_cnt;
                    if (ack_q.size() == 0) begin
                        check_eq("ack_unexpected", EW'(sw_rd_ack_o), '0);
                    end else begin
                        e = ack_q.pop_front();
                        check_eq("sw_ack", EW'({sw_rd_err_o, sw_rd_data_o}), e);
                    end
                end
                if (load_done_o) begin
                    load_done_cnt++;
                    if (pass_q.size() == 0) begin
                        check_eq("pass_unexpected", EW'(load_done_o), '0);
                    end else begin
                        e = pass_q.pop_front();
                        check_eq("pass_result", {shadow_vld_o, timeout_err_o, shadow_o}, e);
                    end
                end
            end else begin
                terr_prev = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        sw_rd_req_i = 1'b0;
        sw_rd_sel_i = '0;
        pgm_req_i   = 1'b0;
        reload_i    = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        mem[0] = 64'h0123_4567_89AB_CDF0;
        mem[1] = 64'h0123_4567_89AB_CD12;
        mem[2] = 64'h0123_4567_89AB_CD34;
        mem[3] = 64'h0123_4567_89AB_CD56;
        for (int k = 0; k < RSEL; k++) exp_sh[k] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");

        // Boot load, with a software request raised during the pass
        push_pass();
        rst_n = 1'b1;
        wait_cnt("boot_first_start", W_START, 1, 50);
        sw_rd_sel_i = 2'd3;
        sw_rd_req_i = 1'b1;
        start_q.push_back(EW'(3));
        ack_q.push_back(EW'({1'b0, mem[3]}));
        wait_cnt("boot_done", W_DONE, 1, 400);
        check_eq("boot_vld", EW'(shadow_vld_o), EW'(1));
        check_eq("boot_terr", EW'(timeout_err_o), '0);
        wait_cnt("sw_boot_ack", W_ACK, 1, 200);
        sw_rd_req_i = 1'b0;
        check_eq("sw_after_boot", EW'(done_at_ack), EW'(1));

        // Software read of segment 2 with new array data
        mem[2] = 64'hDEAD_BEEF_0000_0002;
        exp_sh[2] = mem[2];
        start_q.push_back(EW'(2));
        ack_q.push_back(EW'({1'b0, mem[2]}));
        sw_rd_sel_i = 2'd2;
        sw_rd_req_i = 1'b1;
        wait_cnt("sw2_ack", W_ACK, 2, 200);
        sw_rd_req_i = 1'b0;
        @(negedge clk); #1;
        check_eq("shadow_seg2", EW'(shadow_o[2*NR +: NR]), EW'(64'hDEAD_BEEF_0000_0002));
        repeat (10) @(negedge clk);
        #1;
        check_eq("single_ack", EW'(ack_cnt), EW'(2));

        // Program request and software request together: program wins
        sw_rd_sel_i = 2'd1;
        sw_rd_req_i = 1'b1;
        pgm_req_i   = 1'b1;
        wait_cnt("pgm_gnt", W_GNT, 1, 10);
        repeat (5) @(negedge clk);
        #1;
        pulse_reload();
        repeat (10) @(negedge clk);
        #1;
        check_eq("no_sw_in_pgm", EW'(ack_cnt), EW'(2));
        check_eq("gnt_held", EW'(pgm_gnt_o), EW'(1));
        for (int k = 0; k < RSEL; k++) mem[k] = {$urandom, $urandom};
        push_pass();
        start_q.push_back(EW'(1));
        ack_q.push_back(EW'({1'b0, mem[1]}));
        pgm_req_i = 1'b0;
        @(negedge clk); #1;
        check_eq("gnt_fall", EW'(pgm_gnt_o), '0);
        check_eq("vld_clr_pgm_exit", EW'(shadow_vld_o), '0);
        wait_cnt("pgm_pass_done", W_DONE, 2, 400);
        wait_cnt("sw_after_pgm_ack", W_ACK, 3, 200);
        sw_rd_req_i = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_eq("pgm_reload_absorbed", EW'(load_done_cnt), EW'(2));

        // Timeout: segment 1 never answers
        for (int k = 0; k < RSEL; k++) mem[k] = {$urandom, $urandom};
        noans_en  = 1'b1;
        noans_sel = 1;
        push_pass();
        pulse_reload();
        wait_cnt("tmo_pass_done", W_DONE, 3, 600);
        check_eq("tmo_latency", EW'(terr_rise_cyc - noans_start_cyc), EW'(TMO + 1));
        check_eq("tmo_sticky", EW'(timeout_err_o), EW'(1));
        noans_en = 1'b0;

        // Done on the exact expiry cycle, plus two reloads mid-pass
        exact_mode = 1'b1;
        for (int k = 0; k < RSEL; k++) mem[k] = {$urandom, $urandom};
        push_pass();
        push_pass();
        pulse_reload();
        wait_cnt("reload_mid_pass", W_START, start_cnt + 2, 200);
        pulse_reload();
        repeat (3) @(negedge clk);
        #1;
        pulse_reload();
        wait_cnt("double_pass_done", W_DONE, 5, 1000);
        repeat (40) @(negedge clk);
        #1;
        check_eq("one_extra_pass", EW'(load_done_cnt), EW'(5));
        check_eq("exact_no_err", EW'(timeout_err_o), '0);
        exact_mode = 1'b0;

        // Reset while segment 2 is outstanding
        for (int k = 0; k < RSEL; k++) mem[k] = {$urandom, $urandom};
        push_pass();
        pulse_reload();
        wait_cnt("reach_seg2", W_START, start_cnt + 3, 300);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        start_q.delete();
        pass_q.delete();
        ack_q.delete();
        for (int k = 0; k < RSEL; k++) exp_sh[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < RSEL; k++) mem[k] = {$urandom, $urandom};
        push_pass();
        rst_n = 1'b1;
        wait_cnt("post_reset_pass", W_DONE, 6, 400);
        repeat (10) @(negedge clk);
        #1;

        // Everything expected was produced, nothing more
        check_eq("start_q_empty", EW'(start_q.size()), '0);
        check_eq("ack_q_empty", EW'(ack_q.size()), '0);
        check_eq("pass_q_empty", EW'(pass_q.size()), '0);
        check_eq("total_acks", EW'(ack_cnt), EW'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
